// File: rtl/truth_table_checker_if.sv
// Bundles the checker's control/result handshake and the drive/sense lines
// towards the gate-level circuit under test.
interface truth_table_checker_if #(
  parameter int unsigned N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] vec;
  logic            z_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail;

  // master: whoever launches sweeps and models the circuit's output
  modport master (
    output start, z_in,
    input  vec, busy, done, pass, err_count, first_fail
  );

  // slave: the checker itself
  modport slave (
    input  start, z_in,
    output vec, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive stimulus driver / response checker for a small combinational
// circuit: walks every input vector, samples z_in, compares against EXPECTED.
module truth_table_checker #(
  parameter int unsigned            N_IN     = 3,
  parameter logic [(2**N_IN)-1:0]   EXPECTED = 8'hF8,
  parameter int unsigned            SETTLE   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_checker_if.slave bus
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LastIdx    = '1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StFin    = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            pass_q, pass_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StSample: begin
        if (bus.z_in != EXPECTED[idx_q]) begin
          err_d = err_q + {{N_IN{1'b0}}, 1'b1};
          // err_q still zero means this is the first mismatch of the sweep
          if (err_q == '0) ff_d = idx_q;
        end
        // Terminal test precedes the increment, so idx never wraps.
        if (idx_q == LastIdx) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
          cnt_d   = '0;
          state_d = StDrive;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // vec tracks idx directly, so it keeps the last vector while idle.
  assign bus.vec        = idx_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule
